seq_alu: RTL and testbench
==========================

Name: seq_alu

Overview:
- Execute-stage ALU directly downstream of the operand-2 shifter.
- Consumes SrcA from the register file and the already-shifted SrcB, then performs the operation selected by Alu_Control.
- Registers the result and NZCV flags.
- Logical and arithmetic ops complete in 1 cycle. MUL runs as a 32-iteration shift-add sequence behind a start/busy/done handshake; control logic stalls on busy.

Parameters:
- WIDTH, 32, datapath width of operands and result.
- MUL_ITERS, 32, shift-add iterations for MUL; must equal WIDTH.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  request pulse; operands/control sampled on the edge where start=1 and busy=0.
- SrcA  in  WIDTH  first operand (register file).
- SrcB  in  WIDTH  second operand (shifter output).
- Alu_Control  in  3  operation select.
- ALUResult  out  WIDTH  registered result.
- ALUFlags  out  4  registered {N,Z,C,V}.
- busy  out  1  high while a MUL is in progress.
- done  out  1  one-cycle pulse when ALUResult/ALUFlags update.

Behaviour:
- Reset (reset_n=0, asynchronous):
  - ALUResult=0, ALUFlags=0, busy=0, done=0.
  - State=IDLE; iteration counter and internal registers cleared.
  - Reset during MUL aborts it; no done is produced.
- Alu_Control encoding:
  - 000 ADD A+B; 001 SUB A-B; 010 AND; 011 ORR; 100 MOV (result=SrcB, the shifted operand).
  - 101 MUL (low WIDTH bits of A*B, unsigned/two's-complement identical); 110 EOR; 111 BIC (A & ~B).
- States: IDLE, MUL_RUN.
  - IDLE:
    - start=1 and op!=MUL: at that edge, ALUResult and ALUFlags are written and done=1 for the following cycle. Latency 1 cycle.
    - start=1 and op==MUL: at that edge, latch multiplicand=SrcA, multiplier=SrcB, accumulator=0, count=0; busy=1; go to MUL_RUN.
  - MUL_RUN, each edge:
    - if multiplier[0], accumulator += multiplicand (mod 2^WIDTH);
    - multiplicand <<= 1; multiplier >>= 1; count++.
    - On the edge completing iteration MUL_ITERS (count==MUL_ITERS-1): ALUResult=accumulator result, flags written, done=1 next cycle, busy=0, return to IDLE.
    - MUL latency: 32 cycles from start edge to done.
- start while busy=1: ignored; operands are not re-sampled and the in-flight MUL is unaffected.
- done is high exactly one cycle per accepted start. Back-to-back single-cycle starts give done on consecutive cycles.
- Outputs hold their last value between completions.
- Flags:
  - N=ALUResult[WIDTH-1]; Z=(ALUResult==0).
  - ADD: C=carry-out of bit WIDTH-1; V=(A[msb]==B[msb]) && (R[msb]!=A[msb]).
  - SUB: computed as A+~B+1; C=carry-out (1 = no borrow); V=(A[msb]!=B[msb]) && (R[msb]!=A[msb]).
  - Logical ops, MOV and MUL: C=0, V=0.
- Arithmetic is modulo 2^WIDTH; no saturation.

Test Plan:
- ADD: SrcA=0x7FFFFFFF, SrcB=0x00000001, start -> next cycle ALUResult=0x80000000, ALUFlags=1001 (N=1,Z=0,C=0,V=1), done pulse 1 cycle.
- SUB: SrcA=5, SrcB=5 -> ALUResult=0, flags=0110. SUB 3-5 -> 0xFFFFFFFE, flags=1000.
- Logic/MOV: A=0xF0F0F0F0, B=0xFF00FF00. AND -> 0xF000F000; EOR -> 0x0FF00FF0; BIC -> 0x00F000F0; MOV -> 0xFF00FF00. C=V=0 in every case.
- MUL 123*456:
  - busy high for 32 cycles, done exactly 32 cycles after the start edge.
  - ALUResult=0x0000DB18, flags=0000.
  - MUL 0x00010000*0x00010000 -> 0, Z=1.
  - MUL 0xFFFFFFFF*2 -> 0xFFFFFFFE, N=1.
- start with ADD asserted mid-MUL (cycle 10) -> ignored; MUL result unchanged, single done.
- reset_n low at cycle 15 of a MUL -> ALUResult/flags/busy/done = 0 immediately. After release, a new ADD 2+3 returns 5 in 1 cycle.

Source files
------------

// File: rtl/seq_alu.sv
// -----------------------------------------------------------------------------
// seq_alu
//   Execute-stage ALU that sits directly after the operand-2 shifter. SrcA comes
//   from the register file and SrcB is the already-shifted second operand.
//   Single-cycle ops (ADD, SUB, AND, ORR, MOV, EOR, BIC) write ALUResult/ALUFlags
//   on the accepting edge. MUL runs as a shift-add sequence of MUL_ITERS steps
//   behind a start/busy/done handshake.
//
// Ports
//   clk          in   1      system clock, rising edge
//   reset_n      in   1      asynchronous active-low reset
//   start        in   1      request; sampled on an edge where busy=0
//   SrcA         in   WIDTH  first operand (register file)
//   SrcB         in   WIDTH  second operand (shifter output)
//   Alu_Control  in   3      operation select
//   ALUResult    out  WIDTH  registered result
//   ALUFlags     out  4      registered {N,Z,C,V}
//   busy         out  1      high while a MUL is in flight
//   done         out  1      one-cycle pulse when ALUResult/ALUFlags update
//
// MUL_ITERS is expected to equal WIDTH so that the low WIDTH bits of the
// product are complete when the sequence ends.
// -----------------------------------------------------------------------------
module seq_alu #(
    parameter int WIDTH     = 32,
    parameter int MUL_ITERS = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    input  logic [2:0]       Alu_Control,
    output logic [WIDTH-1:0] ALUResult,
    output logic [3:0]       ALUFlags,
    output logic             busy,
    output logic             done
);

    localparam int CNT_W = (MUL_ITERS > 1) ? $clog2(MUL_ITERS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_ITERS - 1);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_ORR = 3'b011;
    localparam logic [2:0] OP_MOV = 3'b100;
    localparam logic [2:0] OP_MUL = 3'b101;
    localparam logic [2:0] OP_EOR = 3'b110;
    localparam logic [2:0] OP_BIC = 3'b111;

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_MUL_RUN = 1'b1
    } state_t;

    // Pack {N,Z,C,V}; N and Z always derive from the result itself.
    function automatic logic [3:0] make_flags(input logic [WIDTH-1:0] res,
                                              input logic              c_in,
                                              input logic              v_in);
        logic n_bit;
        logic z_bit;
        n_bit = res[WIDTH-1];
        z_bit = (res == {WIDTH{1'b0}});
        return {n_bit, z_bit, c_in, v_in};
    endfunction

    // Registered state
    state_t             state_q,  state_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic [3:0]         flags_q,  flags_d;
    logic               busy_q,   busy_d;
    logic               done_q,   done_d;
    logic [WIDTH-1:0]   acc_q,    acc_d;
    logic [WIDTH-1:0]   mcand_q,  mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [CNT_W-1:0]   count_q,  count_d;

    // Single-cycle datapath signals
    logic [WIDTH-1:0]   b_eff_s;
    logic               cin_s;
    logic [WIDTH:0]     sum_s;
    logic [WIDTH-1:0]   alu_res_s;
    logic               alu_c_s;
    logic               alu_v_s;

    // Multiplier step signal
    logic [WIDTH-1:0]   acc_step_s;

    // Shared adder: SUB is A + ~B + 1 so the carry-out means "no borrow".
    always_comb begin
        b_eff_s = SrcB;
        cin_s   = 1'b0;
        if (Alu_Control == OP_SUB) begin
            b_eff_s = ~SrcB;
            cin_s   = 1'b1;
        end else begin
            b_eff_s = SrcB;
            cin_s   = 1'b0;
        end
        sum_s = {1'b0, SrcA} + {1'b0, b_eff_s} + {{WIDTH{1'b0}}, cin_s};
    end

    // Result and C/V selection for the single-cycle operations.
    always_comb begin
        alu_res_s = {WIDTH{1'b0}};
        alu_c_s   = 1'b0;
        alu_v_s   = 1'b0;
        case (Alu_Control)
            OP_ADD: begin
                alu_res_s = sum_s[WIDTH-1:0];
                alu_c_s   = sum_s[WIDTH];
                alu_v_s   = (SrcA[WIDTH-1] == SrcB[WIDTH-1]) &&
                            (sum_s[WIDTH-1] != SrcA[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res_s = sum_s[WIDTH-1:0];
                alu_c_s   = sum_s[WIDTH];
                alu_v_s   = (SrcA[WIDTH-1] != SrcB[WIDTH-1]) &&
                            (sum_s[WIDTH-1] != SrcA[WIDTH-1]);
            end
            OP_AND:  alu_res_s = SrcA & SrcB;
            OP_ORR:  alu_res_s = SrcA | SrcB;
            OP_MOV:  alu_res_s = SrcB;
            OP_EOR:  alu_res_s = SrcA ^ SrcB;
            OP_BIC:  alu_res_s = SrcA & ~SrcB;
            // MUL never completes through this path; it is handled by the FSM.
            OP_MUL:  alu_res_s = {WIDTH{1'b0}};
            default: alu_res_s = {WIDTH{1'b0}};
        endcase
    end

    // One shift-add step: add the multiplicand when the current multiplier bit is set.
    always_comb begin
        if (mplier_q[0]) begin
            acc_step_s = acc_q + mcand_q;
        end else begin
            acc_step_s = acc_q;
        end
    end

    // FSM next-state and datapath register updates.
    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        flags_d  = flags_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        count_d  = count_q;
        case (state_q)
            ST_IDLE: begin
                busy_d = 1'b0;
                if (start) begin
                    if (Alu_Control == OP_MUL) begin
                        mcand_d  = SrcA;
                        mplier_d = SrcB;
                        acc_d    = {WIDTH{1'b0}};
                        count_d  = {CNT_W{1'b0}};
                        busy_d   = 1'b1;
                        state_d  = ST_MUL_RUN;
                    end else begin
                        result_d = alu_res_s;
                        flags_d  = make_flags(alu_res_s, alu_c_s, alu_v_s);
                        done_d   = 1'b1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_MUL_RUN: begin
                // start is deliberately not looked at here: a request while
                // busy is dropped and the in-flight operands stay untouched.
                acc_d    = acc_step_s;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                count_d  = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
                if (count_q == CNT_LAST) begin
                    // The final step's add must be included in the written result.
                    result_d = acc_step_s;
                    flags_d  = make_flags(acc_step_s, 1'b0, 1'b0);
                    done_d   = 1'b1;
                    busy_d   = 1'b0;
                    count_d  = {CNT_W{1'b0}};
                    state_d  = ST_IDLE;
                end else begin
                    busy_d = 1'b1;
                end
            end
            default: begin
                busy_d  = 1'b0;
                count_d = {CNT_W{1'b0}};
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset also aborts an in-flight MUL.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            result_q <= {WIDTH{1'b0}};
            flags_q  <= 4'b0000;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            acc_q    <= {WIDTH{1'b0}};
            mcand_q  <= {WIDTH{1'b0}};
            mplier_q <= {WIDTH{1'b0}};
            count_q  <= {CNT_W{1'b0}};
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            flags_q  <= flags_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            count_q  <= count_d;
        end
    end

    assign ALUResult = result_q;
    assign ALUFlags  = flags_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_seq_alu.sv
module tb_seq_alu;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_ORR = 3'b011;
    localparam logic [2:0] OP_MOV = 3'b100;
    localparam logic [2:0] OP_MUL = 3'b101;
    localparam logic [2:0] OP_EOR = 3'b110;
    localparam logic [2:0] OP_BIC = 3'b111;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [31:0] SrcA;
    logic [31:0] SrcB;
    logic [2:0]  Alu_Control;
    logic [31:0] ALUResult;
    logic [3:0]  ALUFlags;
    logic        busy;
    logic        done;

    int n_checks = 0;
    int n_fail   = 0;

    // scoreboard entries: {flags[3:0], result[31:0]}
    logic [35:0] sb_q[$];

    seq_alu #(.WIDTH(32), .MUL_ITERS(32)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .SrcA        (SrcA),
        .SrcB        (SrcB),
        .Alu_Control (Alu_Control),
        .ALUResult   (ALUResult),
        .ALUFlags    (ALUFlags),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    // reference model of the ALU
    function automatic logic [35:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [32:0] s;
        logic [63:0] p;
        logic [31:0] r;
        logic        c;
        logic        v;
        r = 32'd0; c = 1'b0; v = 1'b0;
        case (op)
            OP_ADD: begin
                s = {1'b0, a} + {1'b0, b};
                r = s[31:0]; c = s[32];
                v = (a[31] == b[31]) && (r[31] != a[31]);
            end
            OP_SUB: begin
                s = {1'b0, a} + {1'b0, ~b} + 33'd1;
                r = s[31:0]; c = s[32];
                v = (a[31] != b[31]) && (r[31] != a[31]);
            end
            OP_AND: r = a & b;
            OP_ORR: r = a | b;
            OP_MOV: r = b;
            OP_MUL: begin
                p = {32'd0, a} * {32'd0, b};
                r = p[31:0];
            end
            OP_EOR: r = a ^ b;
            OP_BIC: r = a & ~b;
            default: r = 32'd0;
        endcase
        return {r[31], (r == 32'd0), c, v, r};
    endfunction

    // drive one request (caller is at a negedge) and record its expectation
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        Alu_Control = op;
        SrcA        = a;
        SrcB        = b;
        start       = 1'b1;
        sb_q.push_back(model(op, a, b));
    endtask

    task automatic test_reset();
        reset_n = 1'b0; start = 1'b0; SrcA = 32'd0; SrcB = 32'd0; Alu_Control = 3'd0;
        #1;
        n_checks++; if (ALUResult !== 32'd0) begin n_fail++; $display("FAIL reset_result: got %h expected %h", ALUResult, 32'd0); end
        n_checks++; if (ALUFlags !== 4'd0) begin n_fail++; $display("FAIL reset_flags: got %b expected %b", ALUFlags, 4'd0); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_add();
        logic [35:0] exp;
        issue(OP_ADD, 32'h7FFF_FFFF, 32'h0000_0001);
        @(negedge clk);
        start = 1'b0;
        exp = (sb_q.size() > 0) ? sb_q.pop_front() : 36'd0;
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL add_done: got %b expected 1", done); end
        n_checks++; if (ALUResult !== 32'h8000_0000 || ALUFlags !== 4'b1001) begin n_fail++; $display("FAIL add_value: got %h/%b expected 80000000/1001", ALUResult, ALUFlags); end
        n_checks++; if ({ALUFlags, ALUResult} !== exp) begin n_fail++; $display("FAIL add_sb: got %h expected %h", {ALUFlags, ALUResult}, exp); end
        @(negedge clk);
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL add_done_pulse: got %b expected 0", done); end
        n_checks++; if (ALUResult !== 32'h8000_0000) begin n_fail++; $display("FAIL add_hold: got %h expected 80000000", ALUResult); end
    endtask

    task automatic test_sub();
        logic [31:0] a_t[2]   = '{32'd5, 32'd3};
        logic [31:0] b_t[2]   = '{32'd5, 32'd5};
        logic [31:0] r_t[2]   = '{32'h0000_0000, 32'hFFFF_FFFE};
        logic [3:0]  f_t[2]   = '{4'b0110, 4'b1000};
        logic [35:0] exp;
        for (int i = 0; i < 2; i++) begin
            issue(OP_SUB, a_t[i], b_t[i]);
            @(negedge clk);
            start = 1'b0;
            exp = (sb_q.size() > 0) ? sb_q.pop_front() : 36'd0;
            n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL sub_done[%0d]: got %b expected 1", i, done); end
            n_checks++; if (ALUResult !== r_t[i] || ALUFlags !== f_t[i]) begin n_fail++; $display("FAIL sub_value[%0d]: got %h/%b expected %h/%b", i, ALUResult, ALUFlags, r_t[i], f_t[i]); end
            n_checks++; if ({ALUFlags, ALUResult} !== exp) begin n_fail++; $display("FAIL sub_sb[%0d]: got %h expected %h", i, {ALUFlags, ALUResult}, exp); end
            @(negedge clk);
        end
    endtask

    task automatic test_logic();
        logic [2:0]  op_t[5] = '{OP_AND, OP_EOR, OP_BIC, OP_MOV, OP_ORR};
        logic [31:0] r_t[5]  = '{32'hF000_F000, 32'h0FF0_0FF0, 32'h00F0_00F0, 32'hFF00_FF00, 32'hFFF0_FFF0};
        logic [35:0] exp;
        for (int i = 0; i < 5; i++) begin
            issue(op_t[i], 32'hF0F0_F0F0, 32'hFF00_FF00);
            @(negedge clk);
            start = 1'b0;
            exp = (sb_q.size() > 0) ? sb_q.pop_front() : 36'd0;
            n_checks++; if (done !== 1'b1 || ALUResult !== r_t[i]) begin n_fail++; $display("FAIL logic_value[%0d]: got done=%b %h expected done=1 %h", i, done, ALUResult, r_t[i]); end
            n_checks++; if (ALUFlags[1:0] !== 2'b00) begin n_fail++; $display("FAIL logic_cv[%0d]: got %b expected 00", i, ALUFlags[1:0]); end
            n_checks++; if ({ALUFlags, ALUResult} !== exp) begin n_fail++; $display("FAIL logic_sb[%0d]: got %h expected %h", i, {ALUFlags, ALUResult}, exp); end
            @(negedge clk);
        end
    endtask

    task automatic test_mul();
        logic [31:0] a_t[3] = '{32'd123, 32'h0001_0000, 32'hFFFF_FFFF};
        logic [31:0] b_t[3] = '{32'd456, 32'h0001_0000, 32'h0000_0002};
        logic [31:0] r_t[3] = '{32'h0000_DB18, 32'h0000_0000, 32'hFFFF_FFFE};
        logic [3:0]  f_t[3] = '{4'b0000, 4'b0100, 4'b1000};
        logic [35:0] exp;
        int cyc;
        int busy_cnt;
        for (int i = 0; i < 3; i++) begin
            issue(OP_MUL, a_t[i], b_t[i]);
            @(negedge clk);
            start = 1'b0;
            cyc = 0; busy_cnt = 0;
            while (done !== 1'b1 && cyc < 40) begin
                if (busy === 1'b1) busy_cnt++;
                @(negedge clk);
                cyc++;
            end
            exp = (sb_q.size() > 0) ? sb_q.pop_front() : 36'd0;
            n_checks++; if (cyc !== 32) begin n_fail++; $display("FAIL mul_latency[%0d]: got %0d expected 32", i, cyc); end
            n_checks++; if (busy_cnt !== 32) begin n_fail++; $display("FAIL mul_busy_cycles[%0d]: got %0d expected 32", i, busy_cnt); end
            n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mul_busy_end[%0d]: got %b expected 0", i, busy); end
            n_checks++; if (ALUResult !== r_t[i] || ALUFlags !== f_t[i]) begin n_fail++; $display("FAIL mul_value[%0d]: got %h/%b expected %h/%b", i, ALUResult, ALUFlags, r_t[i], f_t[i]); end
            n_checks++; if ({ALUFlags, ALUResult} !== exp) begin n_fail++; $display("FAIL mul_sb[%0d]: got %h expected %h", i, {ALUFlags, ALUResult}, exp); end
            @(negedge clk);
            n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL mul_done_pulse[%0d]: got %b expected 0", i, done); end
        end
    endtask

    task automatic test_mul_ignore_start();
        logic [35:0] exp;
        logic [35:0] got;
        int done_cnt;
        int first;
        issue(OP_MUL, 32'd123, 32'd456);
        @(negedge clk);
        start = 1'b0;
        done_cnt = 0; first = -1; got = 36'd0;
        for (int c = 0; c < 45; c++) begin
            if (c == 10) begin
                start = 1'b1; Alu_Control = OP_ADD; SrcA = 32'hDEAD_0000; SrcB = 32'h0000_BEEF;
            end else begin
                start = 1'b0;
            end
            if (done === 1'b1) begin
                done_cnt++;
                if (first < 0) begin first = c; got = {ALUFlags, ALUResult}; end
            end
            @(negedge clk);
        end
        exp = (sb_q.size() > 0) ? sb_q.pop_front() : 36'd0;
        n_checks++; if (done_cnt !== 1) begin n_fail++; $display("FAIL ignore_done_count: got %0d expected 1", done_cnt); end
        n_checks++; if (first !== 32) begin n_fail++; $display("FAIL ignore_latency: got %0d expected 32", first); end
        n_checks++; if (got !== {4'b0000, 32'h0000_DB18} || got !== exp) begin n_fail++; $display("FAIL ignore_result: got %h expected %h", got, exp); end
    endtask

    task automatic test_reset_mid_mul();
        logic [35:0] exp;
        int done_cnt;
        issue(OP_MUL, 32'd123, 32'd456);
        @(negedge clk);
        start = 1'b0;
        repeat (14) @(negedge clk);
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rst_mul_busy_before: got %b expected 1", busy); end
        reset_n = 1'b0;
        #1;
        sb_q.delete();
        n_checks++; if (ALUResult !== 32'd0 || ALUFlags !== 4'd0) begin n_fail++; $display("FAIL rst_mul_outputs: got %h/%b expected 0/0000", ALUResult, ALUFlags); end
        n_checks++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL rst_mul_handshake: got busy=%b done=%b expected 0/0", busy, done); end
        @(negedge clk);
        reset_n = 1'b1;
        done_cnt = 0;
        for (int c = 0; c < 40; c++) begin
            if (done === 1'b1) done_cnt++;
            @(negedge clk);
        end
        n_checks++; if (done_cnt !== 0) begin n_fail++; $display("FAIL rst_mul_no_done: got %0d expected 0", done_cnt); end
        issue(OP_ADD, 32'd2, 32'd3);
        @(negedge clk);
        start = 1'b0;
        exp = (sb_q.size() > 0) ? sb_q.pop_front() : 36'd0;
        n_checks++; if (done !== 1'b1 || ALUResult !== 32'd5 || ALUFlags !== 4'b0000) begin n_fail++; $display("FAIL rst_then_add: got done=%b %h/%b expected done=1 00000005/0000", done, ALUResult, ALUFlags); end
        n_checks++; if ({ALUFlags, ALUResult} !== exp) begin n_fail++; $display("FAIL rst_then_add_sb: got %h expected %h", {ALUFlags, ALUResult}, exp); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [2:0]  op_t[5] = '{OP_ADD, OP_SUB, OP_ORR, OP_SUB, OP_EOR};
        logic [31:0] a_t[5]  = '{32'hFFFF_FFFF, 32'h8000_0000, 32'h1234_0000, 32'd10, 32'hAAAA_AAAA};
        logic [31:0] b_t[5]  = '{32'h0000_0001, 32'h0000_0001, 32'h0000_5678, 32'd3, 32'hAAAA_AAAA};
        logic [35:0] exp;
        for (int i = 0; i < 5; i++) begin
            issue(op_t[i], a_t[i], b_t[i]);
            @(negedge clk);
            exp = (sb_q.size() > 0) ? sb_q.pop_front() : 36'd0;
            n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL b2b_done[%0d]: got %b expected 1", i, done); end
            n_checks++; if ({ALUFlags, ALUResult} !== exp) begin n_fail++; $display("FAIL b2b_sb[%0d]: got %h expected %h", i, {ALUFlags, ALUResult}, exp); end
        end
        start = 1'b0;
        @(negedge clk);
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL b2b_done_end: got %b expected 0", done); end
        n_checks++; if (sb_q.size() !== 0) begin n_fail++; $display("FAIL sb_empty: got %0d entries expected 0", sb_q.size()); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_logic();
        test_mul();
        test_mul_ignore_start();
        test_reset_mid_mul();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
